uart_tx_sched: RTL and testbench

- Transmit-side controller for the UART transmit FIFO (16-entry, 8-bit, with push/pop/fifo_reset/count interface).
- Arbitrates up to NREQ byte producers (e.g. UMI register write path, debug/loopback injector) onto the single FIFO push port, round-robin.
- Sequences pops toward the serializer and generates THRE/TEMT/low-watermark status.
- Guarantees the FIFO never sees overrun or an empty-pop.

---
 rtl/uart_tx_sched_pkg.sv | 9 +
 rtl/uart_rr_arb.sv | 34 +++
 rtl/uart_tx_sched.sv | 102 ++++++++++
 tb/tb_uart_tx_sched.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_sched_pkg.sv
// Shared constants for the UART transmit path: FIFO geometry and default low-watermark.
package uart_tx_sched_pkg;

  localparam int unsigned UART_FIFO_WIDTH     = 8;
  localparam int unsigned UART_FIFO_DEPTH     = 16;
  localparam int unsigned UART_FIFO_COUNTER_W = 5;
  localparam int unsigned UART_LOW_WM         = 2;

endpackage

// File: rtl/uart_rr_arb.sv
// Round-robin priority select: first asserted request at or after ptr, wrapping modulo NREQ.
module uart_rr_arb #(
  parameter int unsigned NREQ = 2,
  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             gnt_any
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr} + (PTR_W + 1)'(i);
      if (sum >= (PTR_W + 1)'(NREQ)) sum = sum - (PTR_W + 1)'(NREQ);
      idx = sum[PTR_W-1:0];
      if (!gnt_any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        gnt_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// UART TX FIFO controller: round-robin push arbitration, paced pops to the serializer,
// flush handling and THRE/TEMT/low-watermark status.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int unsigned NREQ           = 2,
  parameter int unsigned FIFO_WIDTH     = UART_FIFO_WIDTH,
  parameter int unsigned FIFO_DEPTH     = UART_FIFO_DEPTH,
  parameter int unsigned FIFO_COUNTER_W = UART_FIFO_COUNTER_W,
  parameter int unsigned LOW_WM         = UART_LOW_WM
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*FIFO_WIDTH-1:0] req_data,
  output logic [NREQ-1:0]            req_ready,
  input  logic                       flush,
  output logic                       fifo_push,
  output logic [FIFO_WIDTH-1:0]      fifo_data,
  output logic                       fifo_pop,
  output logic                       fifo_reset,
  input  logic [FIFO_COUNTER_W-1:0]  fifo_count,
  input  logic                       tx_ready,
  input  logic                       tx_busy,
  input  logic                       low_irq_en,
  output logic                       thre,
  output logic                       temt,
  output logic                       irq_low
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned EFF_W = FIFO_COUNTER_W + 1;

  logic [PTR_W-1:0]      rr_q;
  logic                  pop_gap_q;
  logic [NREQ-1:0]       gnt;
  logic [PTR_W-1:0]      gnt_idx;
  logic                  gnt_any;
  logic [EFF_W-1:0]      eff;
  logic                  space;
  logic                  grant;
  logic                  pop_go;
  logic [FIFO_WIDTH-1:0] sel_data;

  uart_rr_arb #(
    .NREQ(NREQ)
  ) u_arb (
    .req    (req_valid),
    .ptr    (rr_q),
    .gnt    (gnt),
    .gnt_idx(gnt_idx),
    .gnt_any(gnt_any)
  );

  // eff is the FIFO count as it will stand after the current edge.
  always_comb begin
    eff = fifo_reset ? '0
                     : EFF_W'(fifo_count) + EFF_W'(fifo_push) - EFF_W'(fifo_pop);
    space     = (eff < EFF_W'(FIFO_DEPTH)) & ~flush & ~fifo_reset;
    grant     = nreset & space & gnt_any;
    req_ready = grant ? gnt : '0;
    pop_go    = tx_ready & (eff != '0) & ~pop_gap_q & ~flush & ~fifo_reset;
    sel_data  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) sel_data = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      fifo_push  <= 1'b0;
      fifo_pop   <= 1'b0;
      fifo_reset <= 1'b0;
      fifo_data  <= '0;
      rr_q       <= '0;
      pop_gap_q  <= 1'b0;
      thre       <= 1'b1;
      temt       <= 1'b1;
      irq_low    <= 1'b0;
    end else begin
      fifo_reset <= flush;
      fifo_push  <= grant;
      fifo_pop   <= pop_go;
      pop_gap_q  <= pop_go;
      if (grant) begin
        fifo_data <= sel_data;
        rr_q      <= (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      thre    <= (eff == '0);
      temt    <= (eff == '0) & ~tx_busy;
      irq_low <= low_irq_en & (eff <= EFF_W'(LOW_WM));
    end
  end

  a_no_overrun : assert property (@(posedge clk) disable iff (!nreset)
    !(fifo_push && !fifo_pop && fifo_count == FIFO_COUNTER_W'(FIFO_DEPTH)));
  a_no_empty_pop : assert property (@(posedge clk) disable iff (!nreset)
    !(fifo_pop && fifo_count == '0));
  a_ready_onehot : assert property (@(posedge clk) $onehot0(req_ready));
  a_ready_valid : assert property (@(posedge clk) (req_ready & ~req_valid) == '0);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched with a behavioural 16-entry FIFO and serializer tap.
module tb_uart_tx_sched;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_data = '0;
  logic [1:0]  req_ready;
  logic        flush = 1'b0;
  logic        fifo_push, fifo_pop, fifo_reset;
  logic [7:0]  fifo_data;
  logic [4:0]  fifo_count;
  logic        tx_ready = 1'b0;
  logic        tx_busy = 1'b0;
  logic        low_irq_en = 1'b0;
  logic        thre, temt, irq_low;

  int total = 0;
  int bad = 0;

  logic [7:0] fifo_mem[$];
  logic [7:0] exp_push[$];
  logic [7:0] exp_pop[$];

  uart_tx_sched #(
    .NREQ          (2),
    .FIFO_WIDTH    (8),
    .FIFO_DEPTH    (16),
    .FIFO_COUNTER_W(5),
    .LOW_WM        (2)
  ) dut (
    .clk       (clk),
    .nreset    (nreset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .flush     (flush),
    .fifo_push (fifo_push),
    .fifo_data (fifo_data),
    .fifo_pop  (fifo_pop),
    .fifo_reset(fifo_reset),
    .fifo_count(fifo_count),
    .tx_ready  (tx_ready),
    .tx_busy   (tx_busy),
    .low_irq_en(low_irq_en),
    .thre      (thre),
    .temt      (temt),
    .irq_low   (irq_low)
  );

  always #5 clk = ~clk;

  // FIFO model: pop before push so a full FIFO accepts a concurrent push.
  always @(posedge clk) begin
    if (!nreset || fifo_reset) begin
      fifo_mem.delete();
    end else begin
      if (fifo_pop && fifo_mem.size() > 0) void'(fifo_mem.pop_front());
      if (fifo_push && fifo_mem.size() < DEPTH) fifo_mem.push_back(fifo_data);
    end
    fifo_count <= 5'(fifo_mem.size());
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %0h expected no such event", name, act);
  endtask

  // Monitor: every push/pop strobe is checked against the scoreboard queues.
  always @(negedge clk) begin
    if (nreset) begin
      if (fifo_push) begin
        check("push_no_overrun", 32'(fifo_mem.size() < DEPTH || fifo_pop), 32'd1);
        if (exp_push.size() == 0) flag("push_unexpected", 32'(fifo_data));
        else check("push_data", 32'(fifo_data), 32'(exp_push.pop_front()));
      end
      if (fifo_pop) begin
        if (fifo_mem.size() == 0) flag("pop_empty", 32'(fifo_count));
        else if (exp_pop.size() == 0) flag("pop_unexpected", 32'(fifo_mem[0]));
        else check("pop_data", 32'(fifo_mem[0]), 32'(exp_pop.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    step();
    nreset = 1'b1;
  endtask

  // Offer bytes base, base+1, ... on producer idx, advancing on each handshake.
  task automatic offer(input int idx, input int n, input logic [7:0] base, input int max_cycles,
                       output int acc);
    logic hs;
    acc = 0;
    for (int c = 0; c < max_cycles && acc < n; c++) begin
      req_valid[idx] = 1'b1;
      req_data[idx*8 +: 8] = base + 8'(acc);
      #1;
      hs = req_ready[idx];
      step();
      if (hs) acc++;
    end
    req_valid[idx] = 1'b0;
  endtask

  initial begin
    int acc;
    logic [7:0] pop_pat;

    // Reset state, with producers asserting valid.
    req_valid = 2'b11;
    req_data  = 16'hBBAA;
    step();
    step();
    #1;
    check("rst_push", 32'(fifo_push), 32'd0);
    check("rst_pop", 32'(fifo_pop), 32'd0);
    check("rst_fifo_reset", 32'(fifo_reset), 32'd0);
    check("rst_data", 32'(fifo_data), 32'd0);
    check("rst_thre", 32'(thre), 32'd1);
    check("rst_temt", 32'(temt), 32'd1);
    check("rst_irq_low", 32'(irq_low), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    req_valid = 2'b00;
    nreset = 1'b1;
    step();

    // Fill: 20 bytes offered, only 16 fit.
    for (int b = 0; b < 16; b++) exp_push.push_back(8'(b));
    offer(0, 20, 8'h00, 30, acc);
    check("t1_accepted", 32'(acc), 32'd16);
    step();
    step();
    check("t1_count", 32'(fifo_count), 32'd16);
    check("t1_thre", 32'(thre), 32'd0);
    req_valid[0] = 1'b1;
    req_data[7:0] = 8'h10;
    #1;
    check("t1_full_ready", 32'(req_ready), 32'd0);
    req_valid = 2'b00;
    for (int b = 0; b < 16; b++) exp_pop.push_back(8'(b));
    tx_ready = 1'b1;
    repeat (40) step();
    tx_ready = 1'b0;
    check("t1_drained", 32'(fifo_count), 32'd0);
    check("t1_thre_empty", 32'(thre), 32'd1);
    check("t1_temt_empty", 32'(temt), 32'd1);

    // Two producers, rr starting at 0: alternating grants.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_push.push_back(8'hAA);
      exp_push.push_back(8'hBB);
    end
    req_data  = 16'hBBAA;
    req_valid = 2'b11;
    for (int c = 0; c < 6; c++) begin
      #1;
      check("t2_ready", 32'(req_ready), (c % 2 == 0) ? 32'd1 : 32'd2);
      step();
    end
    req_valid = 2'b00;
    step();
    step();
    check("t2_count", 32'(fifo_count), 32'd6);

    // Three bytes drained: pops every other cycle.
    do_reset();
    for (int b = 0; b < 3; b++) begin
      exp_push.push_back(8'h31 + 8'(b));
      exp_pop.push_back(8'h31 + 8'(b));
    end
    offer(0, 3, 8'h31, 10, acc);
    check("t3_accepted", 32'(acc), 32'd3);
    step();
    check("t3_count", 32'(fifo_count), 32'd3);
    tx_busy  = 1'b1;
    tx_ready = 1'b1;
    pop_pat  = 8'b0001_0101;
    for (int i = 0; i < 8; i++) begin
      step();
      check("t3_pop", 32'(fifo_pop), 32'(pop_pat[i]));
      if (i == 4) check("t3_thre_before", 32'(thre), 32'd0);
      if (i == 5) begin
        check("t3_thre_after", 32'(thre), 32'd1);
        check("t3_temt_busy", 32'(temt), 32'd0);
      end
    end
    tx_ready = 1'b0;
    tx_busy  = 1'b0;
    step();
    check("t3_temt_idle", 32'(temt), 32'd1);

    // Full FIFO: pop at count 16 opens a grant the same cycle.
    do_reset();
    for (int b = 0; b < 20; b++) begin
      exp_push.push_back(8'h40 + 8'(b));
      exp_pop.push_back(8'h40 + 8'(b));
    end
    offer(0, 16, 8'h40, 20, acc);
    check("t4_accepted", 32'(acc), 32'd16);
    step();
    step();
    check("t4_count", 32'(fifo_count), 32'd16);
    tx_ready = 1'b1;
    req_valid[0] = 1'b1;
    req_data[7:0] = 8'h50;
    #1;
    check("t4_full_ready", 32'(req_ready), 32'd0);
    step();
    check("t4_pop_at_full", 32'(fifo_pop), 32'd1);
    check("t4_count_at_pop", 32'(fifo_count), 32'd16);
    check("t4_ready_at_pop", 32'(req_ready), 32'd1);
    step();
    offer(0, 3, 8'h51, 20, acc);
    check("t4_more_accepted", 32'(acc), 32'd3);
    repeat (50) step();
    tx_ready = 1'b0;
    check("t4_drained", 32'(fifo_count), 32'd0);

    // Flush mid-stream with a byte on offer.
    do_reset();
    for (int b = 0; b < 9; b++) exp_push.push_back(8'h60 + 8'(b));
    offer(0, 9, 8'h60, 15, acc);
    check("t5_accepted", 32'(acc), 32'd9);
    step();
    step();
    check("t5_count", 32'(fifo_count), 32'd9);
    flush    = 1'b1;
    tx_ready = 1'b1;
    req_valid[0] = 1'b1;
    req_data[7:0] = 8'h69;
    #1;
    check("t5_ready_flush", 32'(req_ready), 32'd0);
    step();
    flush = 1'b0;
    check("t5_fifo_reset", 32'(fifo_reset), 32'd1);
    check("t5_push_flush", 32'(fifo_push), 32'd0);
    check("t5_pop_flush", 32'(fifo_pop), 32'd0);
    #1;
    check("t5_ready_reset", 32'(req_ready), 32'd0);
    step();
    check("t5_fifo_reset_off", 32'(fifo_reset), 32'd0);
    check("t5_count_zero", 32'(fifo_count), 32'd0);
    check("t5_thre", 32'(thre), 32'd1);
    check("t5_pop_after", 32'(fifo_pop), 32'd0);
    #1;
    check("t5_ready_after", 32'(req_ready), 32'd1);
    req_valid = 2'b00;
    step();
    check("t5_pop_late", 32'(fifo_pop), 32'd0);
    tx_ready = 1'b0;

    // Low watermark during a drain from 5.
    do_reset();
    low_irq_en = 1'b1;
    for (int b = 0; b < 5; b++) begin
      exp_push.push_back(8'h70 + 8'(b));
      exp_pop.push_back(8'h70 + 8'(b));
    end
    offer(0, 5, 8'h70, 10, acc);
    step();
    step();
    check("t6_count", 32'(fifo_count), 32'd5);
    check("t6_irq_full", 32'(irq_low), 32'd0);
    tx_ready = 1'b1;
    repeat (14) begin
      step();
      check("t6_irq_track", 32'(irq_low), 32'(fifo_count <= 5'd2));
    end
    tx_ready = 1'b0;
    check("t6_irq_empty", 32'(irq_low), 32'd1);

    // Reset mid-drain: four of five bytes leave before nreset.
    for (int b = 0; b < 5; b++) exp_push.push_back(8'h78 + 8'(b));
    for (int b = 0; b < 4; b++) exp_pop.push_back(8'h78 + 8'(b));
    offer(0, 5, 8'h78, 10, acc);
    step();
    step();
    tx_ready = 1'b1;
    repeat (8) step();
    check("t6_mid_count", 32'(fifo_count), 32'd1);
    check("t6_mid_irq", 32'(irq_low), 32'd1);
    check("t6_mid_thre", 32'(thre), 32'd0);
    nreset = 1'b0;
    step();
    check("t6_rst_irq", 32'(irq_low), 32'd0);
    check("t6_rst_thre", 32'(thre), 32'd1);
    check("t6_rst_pop", 32'(fifo_pop), 32'd0);
    nreset = 1'b1;
    tx_ready = 1'b0;
    low_irq_en = 1'b0;
    step();
    step();

    check("end_push_queue", 32'(exp_push.size()), 32'd0);
    check("end_pop_queue", 32'(exp_pop.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
